// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC, synchronous imem interface, and output FIFO with a valid/ready handshake.
// Define FETCH_ZERO_HALT_EN to make a fetched all-zero word halt the fetcher.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0004,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_word,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  output logic        busy,
  output logic        halted
);

  // state   | meaning
  // S_IDLE  | waiting for start after reset
  // S_FETCH | issuing fetches and filling the FIFO
  // S_HALTED| zero word seen; FIFO drains, no issue, waits for start
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [31:0] instr_mem [FIFO_DEPTH];
  logic [31:0] pc_mem    [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic        fetching, redirect, restart, flush;
  logic        pop, capture, push, issue, halt_hit;
  logic [CW:0] used;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign fetching = (state_q == S_FETCH);
  assign redirect = fetching && redirect_valid;
  assign restart  = start && ((state_q == S_IDLE) || (state_q == S_HALTED));
  assign flush    = redirect || restart;

  assign fetch_valid = (count_q != '0);
  assign fetch_instr = instr_mem[rd_ptr_q];
  assign fetch_pc    = pc_mem[rd_ptr_q];
  assign imem_addr   = pc_q;
  assign busy        = fetching;

  // A redirect kills the word returning this cycle; it belongs to the wrong path.
  assign capture = inflight_q && !redirect;

`ifdef FETCH_ZERO_HALT_EN
  assign halt_hit = capture && (imem_word == 32'h0000_0000);
  assign halted   = (state_q == S_HALTED);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign push = capture && !halt_hit;
  assign pop  = fetch_valid && fetch_ready && !flush;

  // Credits: buffered entries plus the one in flight, less the entry leaving now.
  always_comb begin
    used  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue = fetching && !redirect_valid && !halt_hit && (used < DEPTH_C);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (halt_hit) state_d = S_HALTED;
      S_HALTED: if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      if (restart)
        pc_q <= RESET_PC;
      else if (redirect)
        pc_q <= {redirect_pc[31:2], 2'b00};
      else if (issue)
        pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        instr_mem[wr_ptr_q] <= imem_word;
        pc_mem[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: synchronous memory model, handshake, redirect and halt scenarios.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_word = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        busy;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] zero_addr = 32'hFFFF_FFFF;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_word(imem_word),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == zero_addr) return 32'h0000_0000;
    if (a == 32'd4) return 32'h0010_0093;
    if (a == 32'd8) return 32'h0020_0113;
    return a ^ 32'hA500_0013;
  endfunction

  always @(posedge clk) imem_word <= mem_word(imem_addr);

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 0; redirect_valid = 0; redirect_pc = 0; fetch_ready = 0;
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic do_start();
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b exp 0", fetch_valid); end
    vectors++; if (fetch_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h exp 0", fetch_instr); end
    vectors++; if (fetch_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h exp 0", fetch_pc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", busy); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b exp 0", halted); end
    vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL reset_addr: got %h exp 4", imem_addr); end
    cyc();
    rst_n = 1;
    cyc();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_start_busy: got %b exp 0", busy); end
  endtask

  task automatic test_basic_stream();
    logic [31:0] exp_pc;
    do_reset();
    fetch_ready = 1;
    do_start();
    vectors++; if (busy !== 1'b1 || imem_addr !== 32'h4 || fetch_valid !== 1'b0) begin
      miscompares++; $display("FAIL start_state: busy=%b addr=%h valid=%b exp 1/4/0", busy, imem_addr, fetch_valid); end
    cyc();
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL first_latency: valid got %b exp 0", fetch_valid); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h4 || fetch_instr !== 32'h0010_0093) begin
      miscompares++; $display("FAIL first_entry: valid=%b pc=%h instr=%h exp 1/4/00100093", fetch_valid, fetch_pc, fetch_instr); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h8 || fetch_instr !== 32'h0020_0113) begin
      miscompares++; $display("FAIL second_entry: valid=%b pc=%h instr=%h exp 1/8/00200113", fetch_valid, fetch_pc, fetch_instr); end
    for (int k = 2; k < 8; k++) begin
      if (k == 3) start = 1;
      cyc();
      start = 0;
      exp_pc = 32'd4 + 32'(4 * k);
      vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== exp_pc || fetch_instr !== mem_word(exp_pc)) begin
        miscompares++; $display("FAIL stream_%0d: valid=%b pc=%h instr=%h exp pc=%h instr=%h", k, fetch_valid, fetch_pc, fetch_instr, exp_pc, mem_word(exp_pc)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    fetch_ready = 0;
    do_start();
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h4 || fetch_instr !== 32'h0010_0093 || imem_addr !== 32'd12) begin
        miscompares++; $display("FAIL stall_%0d: valid=%b pc=%h instr=%h addr=%h exp 1/4/00100093/c", i, fetch_valid, fetch_pc, fetch_instr, imem_addr); end
      cyc();
    end
    fetch_ready = 1;
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'd4 + 32'(4 * k);
      vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== exp_pc || fetch_instr !== mem_word(exp_pc)) begin
        miscompares++; $display("FAIL drain_%0d: valid=%b pc=%h exp pc=%h", k, fetch_valid, fetch_pc, exp_pc); end
      cyc();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    fetch_ready = 0;
    do_start();
    cyc(); cyc(); cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h4) begin
      miscompares++; $display("FAIL full_before_redirect: valid=%b pc=%h exp 1/4", fetch_valid, fetch_pc); end
    redirect_valid = 1; redirect_pc = 32'd74;
    cyc();
    redirect_valid = 0;
    vectors++; if (fetch_valid !== 1'b0 || imem_addr !== 32'd72) begin
      miscompares++; $display("FAIL redirect_flush: valid=%b addr=%h exp 0/48", fetch_valid, imem_addr); end
    cyc();
    fetch_ready = 1;
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_gap: valid got %b exp 0", fetch_valid); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd72 || fetch_instr !== mem_word(32'd72)) begin
      miscompares++; $display("FAIL redirect_target: valid=%b pc=%h instr=%h exp pc=48", fetch_valid, fetch_pc, fetch_instr); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd76) begin
      miscompares++; $display("FAIL redirect_next: valid=%b pc=%h exp pc=4c", fetch_valid, fetch_pc); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    fetch_ready = 1;
    do_start();
    cyc(); cyc(); cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h8) begin
      miscompares++; $display("FAIL pre_redirect_pop: valid=%b pc=%h exp 1/8", fetch_valid, fetch_pc); end
    redirect_valid = 1; redirect_pc = 32'd200;
    cyc();
    redirect_valid = 0;
    vectors++; if (fetch_valid !== 1'b0 || imem_addr !== 32'd200) begin
      miscompares++; $display("FAIL redirect_pop_flush: valid=%b addr=%h exp 0/c8", fetch_valid, imem_addr); end
    cyc();
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL redirect_pop_gap: valid got %b exp 0", fetch_valid); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd200) begin
      miscompares++; $display("FAIL redirect_pop_target: valid=%b pc=%h exp pc=c8", fetch_valid, fetch_pc); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd204) begin
      miscompares++; $display("FAIL redirect_pop_next: valid=%b pc=%h exp pc=cc", fetch_valid, fetch_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_ready = 1;
    do_start();
    cyc(); cyc();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect_valid = 0;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_target_addr: got %h exp fffffffc", imem_addr); end
    cyc();
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h exp 0", imem_addr); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFFC || fetch_instr !== mem_word(32'hFFFF_FFFC)) begin
      miscompares++; $display("FAIL wrap_entry_top: valid=%b pc=%h instr=%h exp pc=fffffffc", fetch_valid, fetch_pc, fetch_instr); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || fetch_instr !== mem_word(32'h0)) begin
      miscompares++; $display("FAIL wrap_entry_zero: valid=%b pc=%h instr=%h exp pc=0", fetch_valid, fetch_pc, fetch_instr); end
  endtask

  task automatic test_zero_word();
    do_reset();
    zero_addr = 32'd16;
    fetch_ready = 1;
    do_start();
    cyc(); cyc();
    vectors++; if (fetch_pc !== 32'd4) begin miscompares++; $display("FAIL zero_e4: pc got %h exp 4", fetch_pc); end
    cyc();
    vectors++; if (fetch_pc !== 32'd8) begin miscompares++; $display("FAIL zero_e8: pc got %h exp 8", fetch_pc); end
    fetch_ready = 0;
    cyc();
    fetch_ready = 1;
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd12) begin
      miscompares++; $display("FAIL zero_e12: valid=%b pc=%h exp 1/c", fetch_valid, fetch_pc); end
    fetch_ready = 0;
    cyc();
`ifdef FETCH_ZERO_HALT_EN
    vectors++; if (halted !== 1'b1 || busy !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 32'd12) begin
      miscompares++; $display("FAIL halt_enter: halted=%b busy=%b valid=%b pc=%h exp 1/0/1/c", halted, busy, fetch_valid, fetch_pc); end
    fetch_ready = 1;
    cyc();
    vectors++; if (fetch_valid !== 1'b0 || halted !== 1'b1) begin
      miscompares++; $display("FAIL halt_drained: valid=%b halted=%b exp 0/1", fetch_valid, halted); end
    redirect_valid = 1; redirect_pc = 32'd100;
    cyc();
    redirect_valid = 0;
    vectors++; if (fetch_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'd20) begin
      miscompares++; $display("FAIL halt_redirect_ignored: valid=%b halted=%b addr=%h exp 0/1/14", fetch_valid, halted, imem_addr); end
    do_start();
    vectors++; if (busy !== 1'b1 || halted !== 1'b0 || imem_addr !== 32'd4) begin
      miscompares++; $display("FAIL halt_restart: busy=%b halted=%b addr=%h exp 1/0/4", busy, halted, imem_addr); end
    cyc(); cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd4) begin
      miscompares++; $display("FAIL halt_resume_entry: valid=%b pc=%h exp 1/4", fetch_valid, fetch_pc); end
`else
    vectors++; if (halted !== 1'b0 || busy !== 1'b1 || fetch_valid !== 1'b1 || fetch_pc !== 32'd12) begin
      miscompares++; $display("FAIL nohalt_state: halted=%b busy=%b valid=%b pc=%h exp 0/1/1/c", halted, busy, fetch_valid, fetch_pc); end
    fetch_ready = 1;
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd16 || fetch_instr !== 32'h0) begin
      miscompares++; $display("FAIL zero_delivered: valid=%b pc=%h instr=%h exp 1/10/0", fetch_valid, fetch_pc, fetch_instr); end
    cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'd20 || halted !== 1'b0) begin
      miscompares++; $display("FAIL after_zero: valid=%b pc=%h halted=%b exp 1/14/0", fetch_valid, fetch_pc, halted); end
`endif
    zero_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_midrun();
    do_reset();
    fetch_ready = 1;
    do_start();
    cyc(); cyc(); cyc();
    #2;
    rst_n = 0;
    #1;
    vectors++; if (fetch_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h4 || fetch_pc !== 32'h0) begin
      miscompares++; $display("FAIL midrun_reset: valid=%b busy=%b halted=%b addr=%h pc=%h exp 0/0/0/4/0", fetch_valid, busy, halted, imem_addr, fetch_pc); end
    @(negedge clk);
    rst_n = 1;
    cyc();
    vectors++; if (busy !== 1'b0 || fetch_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrun_idle: busy=%b valid=%b exp 0/0", busy, fetch_valid); end
    do_start();
    cyc(); cyc();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h4 || fetch_instr !== 32'h0010_0093) begin
      miscompares++; $display("FAIL midrun_restart: valid=%b pc=%h instr=%h exp 1/4/00100093", fetch_valid, fetch_pc, fetch_instr); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_zero_word();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
